mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 122 ++++++++++++
 tb/tb_mac_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - streaming dot-product accumulator with Karatsuba 16x16 multiplier
module karatsuba_mac_4digit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [15:0] z0;
    logic [15:0] z2;
    logic [8:0]  sa;
    logic [8:0]  sb;
    logic [17:0] z1;
    logic [17:0] mid;

    // Three 8x8-class multiplies instead of four; mid term is always non-negative
    always_comb begin
        z0  = a[7:0] * b[7:0];
        z2  = a[15:8] * b[15:8];
        sa  = {1'b0, a[15:8]} + {1'b0, a[7:0]};
        sb  = {1'b0, b[15:8]} + {1'b0, b[7:0]};
        z1  = sa * sb;
        mid = z1 - {2'b00, z2} - {2'b00, z0};
        p   = {z2, 16'h0000} + {6'b000000, mid, 8'h00} + {16'h0000, z0};
    end
endmodule

module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       op_a;
    logic [15:0]       op_b;
    logic              op_vld;
    logic [31:0]       product;
    logic [ACC_W:0]    sum;
    logic              accept;
    logic              drain;

    karatsuba_mac_4digit u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DONE);
    // clr overrides any handshake, so a beat offered alongside it is dropped
    assign accept    = in_valid && in_ready && !clr;
    assign drain     = out_valid && out_ready;
    assign sum       = {1'b0, out_acc} + (ACC_W + 1)'(product);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (accept) state_nxt = in_last ? FLUSH : ACCUM;
            FLUSH:       state_nxt = DONE;
            DONE:        if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_vld    <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            op_a      <= '0;
            op_b      <= '0;
            op_vld    <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            op_vld <= accept;
            if (accept) begin
                op_a <= in_a;
                op_b <= in_b;
                if (out_count != {CNT_W{1'b1}}) out_count <= out_count + 1'b1;
            end
            if (op_vld) begin
                out_acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) overflow <= 1'b1;
            end
            // No product can be pending in DONE, so draining never races the add
            if (drain) begin
                out_acc   <= '0;
                out_count <= '0;
                overflow  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed self-checking bench for mac_accumulator (ACC_W 40 and 32)
module tb_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        overflow;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_acc32;
    logic [7:0]  out_count32;
    logic        overflow32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .overflow(overflow)
    );

    mac_accumulator #(.ACC_W(32), .CNT_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_acc(out_acc32), .out_count(out_count32), .overflow(overflow32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_count", out_count, 0);
        check("rst_overflow", overflow, 0);
        step();
        rst_n = 1'b1;
        step();

        // Two back-to-back beats
        in_valid = 1'b1; in_a = 16'd1234; in_b = 16'd4321; in_last = 1'b0;
        step();
        in_a = 16'd1111; in_b = 16'd2222; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("b2b_not_yet_valid", out_valid, 0);
        check("b2b_flush_ready", in_ready, 0);
        step();
        check("b2b_out_valid", out_valid, 1);
        check("b2b_out_acc", out_acc, 64'd7800756);
        check("b2b_out_count", out_count, 2);
        check("b2b_overflow", overflow, 0);
        drain_out();
        check("b2b_drained_valid", out_valid, 0);
        check("b2b_drained_ready", in_ready, 1);
        check("b2b_drained_acc", out_acc, 0);
        check("b2b_drained_count", out_count, 0);

        // Single max-decimal beat, then held-off output
        beat(16'd9999, 16'd9999, 1'b1);
        check("single_ready_flush", in_ready, 0);
        check("single_valid_flush", out_valid, 0);
        step();
        check("single_out_valid", out_valid, 1);
        check("single_out_acc", out_acc, 64'd99980001);
        check("single_out_count", out_count, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_acc", out_acc, 64'd99980001);
            check("hold_count", out_count, 1);
            check("hold_ready", in_ready, 0);
        end
        drain_out();
        check("hold_drained_acc", out_acc, 0);
        check("hold_drained_ready", in_ready, 1);
        check("hold_drained_valid", out_valid, 0);

        // Wrap at ACC_W=32, no wrap at 40
        beat(16'hFFFF, 16'hFFFF, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b1);
        step();
        check("ovf32_valid", out_valid32, 1);
        check("ovf32_acc", out_acc32, 64'd4294705154);
        check("ovf32_flag", overflow32, 1);
        check("ovf40_acc", out_acc, 64'd8589672450);
        check("ovf40_flag", overflow, 0);
        drain_out();
        check("ovf32_cleared", overflow32, 0);
        check("ovf32_acc_cleared", out_acc32, 0);

        // Asynchronous reset while in FLUSH
        beat(16'd5, 16'd5, 1'b0);
        beat(16'd5, 16'd5, 1'b1);
        check("flush_count_before_rst", out_count, 2);
        check("flush_acc_before_rst", out_acc, 25);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_acc", out_acc, 0);
        check("async_rst_count", out_count, 0);
        check("async_rst_ready", in_ready, 1);
        check("async_rst_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_valid", out_valid, 0);
        end
        beat(16'd2, 16'd3, 1'b1);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_acc", out_acc, 6);
        check("post_rst_count", out_count, 1);
        drain_out();

        // clr in ACCUM alongside an offered beat
        beat(16'd7, 16'd7, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; in_last = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clr_acc", out_acc, 0);
        check("clr_count", out_count, 0);
        check("clr_ready", in_ready, 1);
        check("clr_valid", out_valid, 0);
        step();
        check("clr_inflight_dropped", out_acc, 0);
        check("clr_still_idle", out_valid, 0);
        beat(16'd10, 16'd10, 1'b1);
        step();
        check("clr_next_valid", out_valid, 1);
        check("clr_next_acc", out_acc, 100);
        check("clr_next_count", out_count, 1);
        drain_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
